// File: rtl/ram_burst_pkg.sv
// Shared definitions for the RAM burst controller.
// Holds the FSM state encoding, default bus widths and the DRAIN hold
// lengths used after the final word of a write or read burst.
package ram_burst_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Write: one extra cycle for the RAM to sample the last strobe.
    // Read: the last address must be sampled, then dout registered into rdata.
    localparam logic [1:0] HOLD_WR = 2'd1;
    localparam logic [1:0] HOLD_RD = 2'd2;

endpackage

// File: rtl/ram_burst_ctrl.sv
// Block-transfer initiator for a single-port synchronous RAM.
// Accepts one command (read/write, base address, length-1), then streams
// write words in or read words out at one word per cycle.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/ready/wr/addr/len command handshake (ready only in IDLE)
//   wdata_valid/ready, wdata    write-word stream (ready in WRITE)
//   rdata_valid/last, rdata     read-word stream, no backpressure
//   done, busy                  end-of-burst pulse, non-idle status
//   cen, wen, addr, din, dout   RAM pins (all outputs registered)
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              done,
    output logic              busy,
    output logic              cen,
    output logic              wen,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]   remain_q, remain_d;
    logic [1:0]          hold_q, hold_d;
    logic                cen_q, cen_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                done_q, done_d;
    // Read-return pipeline: marks the final address on the pins, then
    // tracks when dout holds valid data, then the registered rdata.
    logic                last_q, last_d;
    logic                dval_q, dlast_q;
    logic                rvalid_q, rlast_q;
    logic [DATA_W-1:0]   rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            hold_q     <= '0;
            cen_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
            dval_q     <= 1'b0;
            dlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            hold_q     <= hold_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            done_q     <= done_d;
            last_q     <= last_d;
            // The RAM samples a read strobe on this edge; dout is valid after it.
            dval_q     <= cen_q & ~wen_q;
            dlast_q    <= last_q;
            rvalid_q   <= dval_q;
            rlast_q    <= dlast_q;
            if (dval_q) rdata_q <= dout;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        hold_d     = hold_q;
        cen_d      = 1'b0;
        wen_d      = 1'b0;
        addr_d     = addr_q;   // address and data hold while cen is low
        din_d      = din_q;
        done_d     = 1'b0;
        last_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d = cmd_addr;
                    remain_d   = cmd_len;
                    state_d    = cmd_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wdata_valid) begin
                    cen_d      = 1'b1;
                    wen_d      = 1'b1;
                    addr_d     = cur_addr_q;
                    din_d      = wdata;
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    remain_d   = remain_q - ADDR_W'(1);
                    if (remain_q == '0) begin
                        state_d = ST_DRAIN;
                        hold_d  = HOLD_WR;
                    end
                end
            end
            ST_READ: begin
                cen_d      = 1'b1;
                addr_d     = cur_addr_q;
                cur_addr_d = cur_addr_q + ADDR_W'(1);
                remain_d   = remain_q - ADDR_W'(1);
                if (remain_q == '0) begin
                    last_d  = 1'b1;
                    state_d = ST_DRAIN;
                    hold_d  = HOLD_RD;
                end
            end
            ST_DRAIN: begin
                if (hold_q == 2'd1) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    hold_d = hold_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wdata_ready = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign cen         = cen_q;
    assign wen         = wen_q;
    assign addr        = addr_q;
    assign din         = din_q;
    assign done        = done_q;
    assign rdata_valid = rvalid_q;
    assign rdata_last  = rlast_q;
    assign rdata       = rdata_q;

endmodule
